// File: rtl/register_file_pkg.sv
// Shared widths and scan-state encoding for the register file and its neighbouring pipeline stages.
package register_file_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ADDR_W   = 2;
  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_t;

endpackage

// File: rtl/register_file_if.sv
// Write/read operand bus plus the valid/ready debug dump port of the register file.
interface register_file_if;
  import register_file_pkg::*;

  logic              RegWrite;
  logic [ADDR_W-1:0] WriteAddr;
  logic [DATA_W-1:0] WriteData;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              dump_req;
  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;
  logic              dump_busy;
  logic              dump_done;

  modport master (
    output RegWrite, WriteAddr, WriteData, rs_addr, rt_addr, dump_req, dump_ready,
    input  rs_data, rt_data, dump_valid, dump_addr, dump_data, dump_busy, dump_done
  );

  modport slave (
    input  RegWrite, WriteAddr, WriteData, rs_addr, rt_addr, dump_req, dump_ready,
    output rs_data, rt_data, dump_valid, dump_addr, dump_data, dump_busy, dump_done
  );

endinterface

// File: rtl/register_file_scan_fsm.sv
// Scan FSM: streams every register out as valid/ready beats, fetching the next beat's
// value through a bypassed read port so a write on the accepting edge is captured.
module reg_scan_fsm
  import register_file_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_dump_req,
  input  logic              i_dump_ready,
  output logic              o_dump_valid,
  output logic [ADDR_W-1:0] o_dump_addr,
  output logic [DATA_W-1:0] o_dump_data,
  output logic              o_dump_busy,
  output logic              o_dump_done,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data
);

  scan_state_t       r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_idx, w_idx_nxt;
  logic [DATA_W-1:0] r_data, w_data_nxt;
  logic              r_valid, r_busy, r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_data  <= w_data_nxt;
      r_valid <= (w_state_nxt == ST_SCAN);
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_data_nxt  = r_data;
    case (r_state)
      ST_IDLE: begin
        if (i_dump_req) begin
          w_state_nxt = ST_SCAN;
          w_idx_nxt   = '0;
          w_data_nxt  = '0;
        end
      end
      ST_SCAN: begin
        if (i_dump_ready) begin
          if (r_idx == ADDR_W'(NUM_REGS - 1)) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_idx_nxt  = r_idx + ADDR_W'(1);
            w_data_nxt = i_rd_data;
          end
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Next beat's register; value is ignored on the final beat where this wraps.
  assign o_rd_addr    = r_idx + ADDR_W'(1);
  assign o_dump_valid = r_valid;
  assign o_dump_addr  = r_idx;
  assign o_dump_data  = r_data;
  assign o_dump_busy  = r_busy;
  assign o_dump_done  = r_done;

endmodule

// File: rtl/register_file.sv
// Architectural register file: r0 hardwired to zero, two write-through read ports,
// and a debug scan port driven by reg_scan_fsm.
module register_file
  import register_file_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  register_file_if.slave bus
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [ADDR_W-1:0] w_scan_addr;
  logic [DATA_W-1:0] w_scan_data;

  // Bypassed read: r0 is zero, a same-cycle write to the address wins over storage.
  function automatic logic [DATA_W-1:0] f_read(
    input logic [ADDR_W-1:0] addr,
    input logic              we,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata,
    input logic [DATA_W-1:0] stored
  );
    if (addr == '0)              return '0;
    if (we && (waddr == addr))   return wdata;
    return stored;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (bus.RegWrite && (bus.WriteAddr != '0)) begin
      r_regs[bus.WriteAddr] <= bus.WriteData;
    end
  end

  assign bus.rs_data = f_read(bus.rs_addr, bus.RegWrite, bus.WriteAddr, bus.WriteData,
                              r_regs[bus.rs_addr]);
  assign bus.rt_data = f_read(bus.rt_addr, bus.RegWrite, bus.WriteAddr, bus.WriteData,
                              r_regs[bus.rt_addr]);
  assign w_scan_data = f_read(w_scan_addr, bus.RegWrite, bus.WriteAddr, bus.WriteData,
                              r_regs[w_scan_addr]);

  reg_scan_fsm u_scan (
    .clk          (clk),
    .rst          (rst),
    .i_dump_req   (bus.dump_req),
    .i_dump_ready (bus.dump_ready),
    .o_dump_valid (bus.dump_valid),
    .o_dump_addr  (bus.dump_addr),
    .o_dump_data  (bus.dump_data),
    .o_dump_busy  (bus.dump_busy),
    .o_dump_done  (bus.dump_done),
    .o_rd_addr    (w_scan_addr),
    .i_rd_data    (w_scan_data)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed plus randomized bench for register_file against a beat-level behavioural model.
module tb_register_file;
  import register_file_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  register_file_if bus ();

  register_file dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference state: register contents and the beat currently expected on the dump port.
  logic [DATA_W-1:0] m_regs [NUM_REGS];
  bit                sm_active;
  bit                sm_done;
  int                sm_idx;
  logic [DATA_W-1:0] sm_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] exp_read(input logic [ADDR_W-1:0] a);
    if (a == 0) return '0;
    if (bus.RegWrite === 1'b1 && bus.WriteAddr == a) return bus.WriteData;
    return m_regs[a];
  endfunction

  // Advance one clock; the model consumes the inputs that were stable before the edge.
  task automatic tick();
    logic              we, r, req, acc;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    we  = bus.RegWrite;  wa = bus.WriteAddr; wd = bus.WriteData;
    r   = rst;           req = bus.dump_req; acc = bus.dump_ready;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
      sm_active = 0; sm_done = 0; sm_idx = 0; sm_data = '0;
    end else begin
      if (we && wa != 0) m_regs[wa] = wd;
      if (sm_done) sm_done = 0;
      else if (!sm_active) begin
        if (req) begin sm_active = 1; sm_idx = 0; sm_data = '0; end
      end else if (acc) begin
        if (sm_idx == NUM_REGS - 1) begin sm_active = 0; sm_done = 1; end
        else begin sm_idx++; sm_data = m_regs[sm_idx]; end
      end
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rs"},    32'(bus.rs_data),    32'(exp_read(bus.rs_addr)));
    chk({tag, ".rt"},    32'(bus.rt_data),    32'(exp_read(bus.rt_addr)));
    chk({tag, ".valid"}, 32'(bus.dump_valid), 32'(sm_active));
    chk({tag, ".busy"},  32'(bus.dump_busy),  32'(sm_active | sm_done));
    chk({tag, ".done"},  32'(bus.dump_done),  32'(sm_done));
    if (sm_active) begin
      chk({tag, ".daddr"}, 32'(bus.dump_addr), 32'(sm_idx));
      chk({tag, ".ddata"}, 32'(bus.dump_data), 32'(sm_data));
    end
  endtask

  task automatic write_reg(input int a, input logic [DATA_W-1:0] d);
    bus.RegWrite = 1'b1; bus.WriteAddr = ADDR_W'(a); bus.WriteData = d;
    tick();
    bus.RegWrite = 1'b0;
  endtask

  task automatic chk_beat(input string tag, input int a, input logic [DATA_W-1:0] d);
    chk({tag, ".valid"}, 32'(bus.dump_valid), 32'd1);
    chk({tag, ".addr"},  32'(bus.dump_addr),  32'(a));
    chk({tag, ".data"},  32'(bus.dump_data),  32'(d));
  endtask

  logic [DATA_W-1:0] beat_vals [NUM_REGS];

  initial begin
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
    sm_active = 0; sm_done = 0; sm_idx = 0; sm_data = '0;
    rst = 1'b1;
    bus.RegWrite = 1'b0; bus.WriteAddr = '0; bus.WriteData = '0;
    bus.rs_addr = '0; bus.rt_addr = '0; bus.dump_req = 1'b0; bus.dump_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state: all outputs low, every address reads zero on both ports.
    chk("rst.valid", 32'(bus.dump_valid), 32'd0);
    chk("rst.busy",  32'(bus.dump_busy),  32'd0);
    chk("rst.done",  32'(bus.dump_done),  32'd0);
    chk("rst.daddr", 32'(bus.dump_addr),  32'd0);
    chk("rst.ddata", 32'(bus.dump_data),  32'd0);
    for (int a = 0; a < NUM_REGS; a++) begin
      bus.rs_addr = ADDR_W'(a); bus.rt_addr = ADDR_W'(NUM_REGS - 1 - a); #1;
      chk("rst.rs", 32'(bus.rs_data), 32'd0);
      chk("rst.rt", 32'(bus.rt_data), 32'd0);
    end

    // Plain write then read next cycle.
    write_reg(2, 8'hA5);
    bus.rs_addr = 2'd2; #1;
    chk("wr2.rs", 32'(bus.rs_data), 32'hA5);

    // Same-cycle write-through on both ports.
    bus.RegWrite = 1'b1; bus.WriteAddr = 2'd3; bus.WriteData = 8'h3C;
    bus.rs_addr = 2'd3; bus.rt_addr = 2'd3; #1;
    chk("byp.rs", 32'(bus.rs_data), 32'h3C);
    chk("byp.rt", 32'(bus.rt_data), 32'h3C);
    tick(); bus.RegWrite = 1'b0; #1;
    chk("byp.after", 32'(bus.rs_data), 32'h3C);

    // r0 writes are discarded, including the bypass path.
    bus.RegWrite = 1'b1; bus.WriteAddr = 2'd0; bus.WriteData = 8'hFF;
    bus.rs_addr = 2'd0; bus.rt_addr = 2'd0; #1;
    chk("r0byp.rs", 32'(bus.rs_data), 32'd0);
    chk("r0byp.rt", 32'(bus.rt_data), 32'd0);
    tick(); bus.RegWrite = 1'b0; #1;
    chk("r0.rs", 32'(bus.rs_data), 32'd0);

    // Full scan with ready held high.
    write_reg(1, 8'h11); write_reg(2, 8'h22); write_reg(3, 8'h33);
    beat_vals[0] = 8'h00; beat_vals[1] = 8'h11; beat_vals[2] = 8'h22; beat_vals[3] = 8'h33;
    bus.dump_ready = 1'b1; bus.dump_req = 1'b1;
    chk("scan.idle_valid", 32'(bus.dump_valid), 32'd0);
    tick(); bus.dump_req = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) begin
      chk_beat("scan.beat", k, beat_vals[k]);
      chk("scan.busy", 32'(bus.dump_busy), 32'd1);
      tick();
    end
    chk("scan.done",   32'(bus.dump_done),  32'd1);
    chk("scan.dbusy",  32'(bus.dump_busy),  32'd1);
    chk("scan.dvalid", 32'(bus.dump_valid), 32'd0);
    tick();
    chk("scan.done_clr", 32'(bus.dump_done), 32'd0);
    chk("scan.idle",     32'(bus.dump_busy), 32'd0);

    // Backpressure on beat 1 while reg1 changes; reg2 written on the accepting edge.
    bus.dump_ready = 1'b0; bus.dump_req = 1'b1;
    tick(); bus.dump_req = 1'b0;
    chk_beat("hold.b0", 0, 8'h00);
    bus.dump_ready = 1'b1;
    tick();
    bus.dump_ready = 1'b0;
    bus.RegWrite = 1'b1; bus.WriteAddr = 2'd1; bus.WriteData = 8'h99;
    for (int c = 0; c < 3; c++) begin
      chk_beat("hold.b1", 1, 8'h11);
      tick();
    end
    bus.WriteAddr = 2'd2; bus.WriteData = 8'h77; bus.dump_ready = 1'b1;
    chk_beat("hold.b1acc", 1, 8'h11);
    tick();
    bus.RegWrite = 1'b0; bus.dump_ready = 1'b0;
    chk_beat("hold.b2", 2, 8'h77);
    bus.rs_addr = 2'd1; #1;
    chk("hold.r1", 32'(bus.rs_data), 32'h99);

    // Reset mid-scan, with a write on the same edge that must be lost.
    rst = 1'b1;
    bus.RegWrite = 1'b1; bus.WriteAddr = 2'd1; bus.WriteData = 8'h5A;
    tick();
    rst = 1'b0; bus.RegWrite = 1'b0;
    chk("mrst.valid", 32'(bus.dump_valid), 32'd0);
    chk("mrst.busy",  32'(bus.dump_busy),  32'd0);
    chk("mrst.done",  32'(bus.dump_done),  32'd0);
    for (int a = 0; a < NUM_REGS; a++) begin
      bus.rs_addr = ADDR_W'(a); bus.rt_addr = ADDR_W'(a); #1;
      chk("mrst.rs", 32'(bus.rs_data), 32'd0);
      chk("mrst.rt", 32'(bus.rt_data), 32'd0);
    end
    tick();
    chk("mrst.nodone", 32'(bus.dump_done), 32'd0);

    // Randomized traffic against the model: writes, reads, scans, backpressure, resets.
    for (int n = 0; n < 600; n++) begin
      rst            = ($urandom_range(0, 79) == 0);
      bus.RegWrite   = 1'($urandom_range(0, 1));
      bus.WriteAddr  = ADDR_W'($urandom);
      bus.WriteData  = DATA_W'($urandom);
      bus.rs_addr    = ADDR_W'($urandom);
      bus.rt_addr    = ADDR_W'($urandom);
      bus.dump_req   = ($urandom_range(0, 5) == 0);
      bus.dump_ready = ($urandom_range(0, 2) != 0);
      #1;
      check_all("rnd");
      tick();
    end
    rst = 1'b0; bus.RegWrite = 1'b0; bus.dump_req = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register_file.md
# register_file

Architectural register file that sits directly downstream of the write-address select stage: it consumes the selected write address, write data and write enable, and supplies two combinational read operands to the ALU stage. It holds 2**ADDR_W registers with register 0 hardwired to zero, forwards same-cycle writes to the read ports, and contains a small scan FSM that streams every register out over a valid/ready debug port on request.

## Interface
- DATA_W, 8: register and data width in bits.
- ADDR_W, 2: register address width; NUM_REGS = 2**ADDR_W.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- RegWrite  in  1  write enable for the current cycle.
- WriteAddr  in  ADDR_W  destination register from the write-address select stage.
- WriteData  in  DATA_W  data to be written.
- rs_addr  in  ADDR_W  read port A address.
- rt_addr  in  ADDR_W  read port B address.
- rs_data  out  DATA_W  read port A data (combinational).
- rt_data  out  DATA_W  read port B data (combinational).
- dump_req  in  1  single-cycle or level request to start a register scan.
- dump_valid  out  1  a scan beat is presented.
- dump_ready  in  1  consumer accepts the current beat.
- dump_addr  out  ADDR_W  register index of the current beat.
- dump_data  out  DATA_W  register value of the current beat.
- dump_busy  out  1  high while the scan FSM is not IDLE.
- dump_done  out  1  one-cycle pulse after the last beat is accepted.

## Operation
- Write: on a rising edge with RegWrite=1 and WriteAddr!=0, regs[WriteAddr] <= WriteData. Writes to address 0 are discarded.
- Read: an address of 0 returns 0. If RegWrite=1 and WriteAddr equals the nonzero read address, the port returns WriteData (write-through bypass). Otherwise the port returns regs[addr]. Both ports are independent and may use the same address.
- Scan FSM states: IDLE, SCAN, DONE.
  - IDLE: on dump_req=1, go to SCAN with idx=0, and load dump_data with the register 0 value (always 0).
  - SCAN: dump_valid=1, dump_addr=idx.
    - Beat accepted (dump_valid & dump_ready) with idx<NUM_REGS-1: idx increments and dump_data loads the post-edge value of regs[idx+1]. The loaded value includes any write that commits on the same edge, via the bypass logic.
    - Beat accepted with idx==NUM_REGS-1: go to DONE.
    - No acceptance: hold dump_addr and dump_data stable. Register writes during the hold do not alter the presented beat.
  - DONE: dump_done=1 for exactly one cycle, then IDLE. dump_req is ignored outside IDLE.
- Normal reads and writes are never stalled by a scan.
- dump_busy=1 in SCAN and DONE.

## Timing
- Reset values: all regs 0, FSM IDLE, idx 0, dump_valid 0, dump_addr 0, dump_data 0, dump_busy 0, dump_done 0.
- A write becomes visible in regs at the next edge. It is visible on read ports in the same cycle via the bypass.
- Scan latency:
  - dump_req sampled at edge N gives dump_valid=1 in cycle N+1.
  - Each accepted beat advances by one cycle. With dump_ready held high, a full scan occupies NUM_REGS cycles of valid, then one DONE cycle.
  - A new request is accepted no earlier than the cycle after DONE.
- rst mid-scan: the next edge returns to IDLE, drops dump_valid, clears regs, and emits no dump_done.
- rst with RegWrite=1 on the same edge: reset wins and the write is lost.

## Structure
- Shared package holds the scan-state enum (IDLE/SCAN/DONE) and the DATA_W/ADDR_W defaults shared with the write-address select stage and the ALU.
- One sub-module: reg_scan_fsm. It contains the state, idx and handshake logic, and reads register contents through a bypassed read port supplied by the parent.
- The storage array and both read ports stay in register_file.

## Test plan
- Reset, then read all addresses on both ports -> rs_data=rt_data=0. Write 0xA5 to reg 2 -> reading reg 2 in the next cycle gives 0xA5.
- RegWrite=1, WriteAddr=3, WriteData=0x3C, rs_addr=rt_addr=3 in the same cycle -> both ports show 0x3C that cycle; regs[3]=0x3C afterwards.
- Write 0xFF to reg 0 -> reg 0 reads 0. Same-cycle bypass to address 0 also reads 0.
- Preload regs {0,0x11,0x22,0x33}, pulse dump_req with dump_ready=1 -> beats (0,0x00),(1,0x11),(2,0x22),(3,0x33) on consecutive cycles, then dump_done high for one cycle.
- Scan with dump_ready=0 held for 3 cycles on beat 1 while reg 1 is written to 0x99 -> beat stays (1,0x11) until accepted. Write reg 2 to 0x77 on the edge that accepts beat 1 -> beat 2 shows 0x77.
- Assert rst during beat 2 -> next cycle dump_valid=0, dump_busy=0, no dump_done, all regs read 0.
